// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round controller: FSM encoding,
// round counts per key size and block geometry.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    localparam int BLOCK_W = 128;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle for aes_round_ctrl; the dec/dp_inv
// pair exists only when AES_ROUND_CTRL_DECRYPT_EN is defined.
interface aes_round_ctrl_if #(
    parameter int RW = 4
);

    logic          in_valid;
    logic          in_ready;
    logic          rk_req;
    logic [RW-1:0] rk_idx;
    logic          rk_valid;
    logic          dp_ld;
    logic          dp_sel_in;
    logic          dp_mix_en;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    logic          dec;
    logic          dp_inv;
`endif

    // master is the controller; slave is the surrounding datapath/key schedule
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    modport master (
        input  in_valid, rk_valid, out_ready, dec,
        output in_ready, rk_req, rk_idx, dp_ld, dp_sel_in, dp_mix_en,
               out_valid, busy, dp_inv
    );

    modport slave (
        output in_valid, rk_valid, out_ready, dec,
        input  in_ready, rk_req, rk_idx, dp_ld, dp_sel_in, dp_mix_en,
               out_valid, busy, dp_inv
    );
`else
    modport master (
        input  in_valid, rk_valid, out_ready,
        output in_ready, rk_req, rk_idx, dp_ld, dp_sel_in, dp_mix_en,
               out_valid, busy
    );

    modport slave (
        output in_valid, rk_valid, out_ready,
        input  in_ready, rk_req, rk_idx, dp_ld, dp_sel_in, dp_mix_en,
               out_valid, busy
    );
`endif

endinterface

// File: rtl/aes_round_cnt.sv
// Round-key index counter: counts up for encryption, down for decryption,
// and saturates at the ends instead of wrapping.
module aes_round_cnt #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [RW-1:0] load_val,
    input  logic          step,
    input  logic          down,
    output logic [RW-1:0] cnt,
    output logic          term
);

    localparam logic [RW-1:0] NR_V    = RW'(NR);
    localparam logic [RW-1:0] LAST_UP = RW'(NR - 1);
    localparam logic [RW-1:0] ONE     = RW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            if (down) begin
                if (cnt != '0) begin
                    cnt <= cnt - ONE;
                end
            end else if (cnt != NR_V) begin
                cnt <= cnt + ONE;
            end
        end
    end

    // term marks the last middle round, after which the final round follows
    assign term = down ? (cnt == ONE) : (cnt == LAST_UP);

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= NR_V);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer driving a shared round datapath and key schedule.
// Define AES_ROUND_CTRL_DECRYPT_EN to add the dec input and dp_inv output.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int RW = 4
) (
    input logic              clk,
    input logic              rst_n,
    aes_round_ctrl_if.master bus
);

    localparam logic [RW-1:0] NR_IDX      = RW'(NR);
    localparam bit            MULTI_ROUND = (NR > 1);

    ctrl_state_t   state;
    ctrl_state_t   next_state;

    logic [RW-1:0] cnt;
    logic [RW-1:0] cnt_load_val;
    logic          cnt_term;
    logic          cnt_clear;
    logic          cnt_load;
    logic          cnt_step;
    logic          cnt_down;

    logic          accept;
    logic          in_ready;
    logic          rk_req;
    logic          dp_ld;
    logic          dp_sel_in;
    logic          dp_mix_en;
    logic          out_valid;
    logic          busy;

    assign accept = (state == ST_IDLE) && bus.in_valid;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    logic dec_q;

    // direction is latched at accept so it stays fixed for the whole block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= bus.dec;
        end
    end

    assign cnt_down     = dec_q;
    assign cnt_load_val = bus.dec ? NR_IDX : '0;
    assign bus.dp_inv   = dec_q & busy;
`else
    assign cnt_down     = 1'b0;
    assign cnt_load_val = '0;
`endif

    // the counter holds the key index itself, so rk_idx needs no remapping
    assign cnt_clear = (state == ST_DONE) && bus.out_ready;
    assign cnt_load  = accept;
    assign cnt_step  = dp_ld && (state != ST_FINAL);

    aes_round_cnt #(
        .NR (NR),
        .RW (RW)
    ) u_round_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .step     (cnt_step),
        .down     (cnt_down),
        .cnt      (cnt),
        .term     (cnt_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) next_state = ST_INIT;
            ST_INIT:  if (bus.rk_valid) next_state = MULTI_ROUND ? ST_ROUND : ST_FINAL;
            ST_ROUND: if (bus.rk_valid && cnt_term) next_state = ST_FINAL;
            ST_FINAL: if (bus.rk_valid) next_state = ST_DONE;
            ST_DONE:  if (bus.out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // loads happen only on an acknowledged key; select lines stay 0 otherwise
    always_comb begin
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        dp_ld     = 1'b0;
        dp_sel_in = 1'b0;
        dp_mix_en = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_INIT: begin
                rk_req    = 1'b1;
                dp_ld     = bus.rk_valid;
                dp_sel_in = bus.rk_valid;
            end
            ST_ROUND: begin
                rk_req    = 1'b1;
                dp_ld     = bus.rk_valid;
                dp_mix_en = bus.rk_valid;
            end
            ST_FINAL: begin
                rk_req = 1'b1;
                dp_ld  = bus.rk_valid;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    assign bus.in_ready  = in_ready;
    assign bus.rk_req    = rk_req;
    assign bus.rk_idx    = rk_req ? cnt : '0;
    assign bus.dp_ld     = dp_ld;
    assign bus.dp_sel_in = dp_sel_in;
    assign bus.dp_mix_en = dp_mix_en;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;

    a_ld_qualified: assert property (@(posedge clk) disable iff (!rst_n)
        dp_ld |-> (rk_req && bus.rk_valid));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !bus.out_ready) |=> out_valid);

endmodule
